// File: rtl/monitor_mem_pkg.sv
// Shared types and defaults for the monitor memory arbiter.
// Optional feature macro: MONITOR_ARB_HOST_PRIO_EN (host always wins ties).
package monitor_mem_pkg;

    localparam int unsigned AddrWDefault = 13;
    localparam int unsigned DataWDefault = 32;

    // Requester identity; doubles as the index into the per-requester port vectors.
    typedef enum logic {
        ReqCpu  = 1'b0,
        ReqHost = 1'b1
    } req_id_e;

    // One slot of the outstanding-read pipeline.
    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_pend_t;

endpackage

// File: rtl/monitor_mem_rr_arb.sv
// Two-requester grant logic with a last-granted pointer.
// Macro MONITOR_ARB_HOST_PRIO_EN: fixed host priority, pointer not built.
module monitor_mem_rr_arb
    import monitor_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] ack
);

`ifdef MONITOR_ARB_HOST_PRIO_EN

    // Host wins any tie; grants are suppressed while reset is asserted.
    always_comb begin
        ack = 2'b00;
        if (reset_n) begin
            if (req[1]) begin
                ack = 2'b10;
            end else if (req[0]) begin
                ack = 2'b01;
            end
        end
    end

`else

    req_id_e last_q;

    // Round-robin grant: on a tie, serve whoever was not granted last.
    always_comb begin
        ack = 2'b00;
        if (reset_n) begin
            unique case (req)
                2'b01:   ack = 2'b01;
                2'b10:   ack = 2'b10;
                2'b11:   ack = (last_q == ReqHost) ? 2'b01 : 2'b10;
                default: ack = 2'b00;
            endcase
        end
    end

    // Pointer moves only when a grant (and hence a transfer) happens; reset favours the CPU.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= ReqHost;
        end else if (ack[0]) begin
            last_q <= ReqCpu;
        end else if (ack[1]) begin
            last_q <= ReqHost;
        end
    end

`endif

endmodule

// File: rtl/monitor_mem_arbiter.sv
// Arbitrates a CPU and a monitor host onto one single-port synchronous memory.
// Transfer in T -> memory command in T+1 -> read data returned in T+3.
// Macro MONITOR_ARB_HOST_PRIO_EN: host wins ties instead of round-robin.
module monitor_mem_arbiter
    import monitor_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            rq_req,
    input  logic [2*ADDR_W-1:0]   rq_addr,
    input  logic [DATA_W/4-1:0]   rq_be,
    input  logic [1:0]            rq_write,
    input  logic [2*DATA_W-1:0]   rq_wdata,
    output logic [1:0]            rq_ack,
    output logic [1:0]            rq_rvalid,
    output logic [DATA_W-1:0]     rq_rdata,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    output logic                  mem_reset_req,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int unsigned BeW = DATA_W / 8;

    logic [1:0]        ack;
    logic              xfer;
    req_id_e           gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [BeW-1:0]    sel_be;
    logic              sel_write;
    logic [DATA_W-1:0] sel_wdata;

    logic [ADDR_W-1:0] addr_q;
    logic [BeW-1:0]    be_q;
    logic              cs_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;

    rd_pend_t          pend1_q;
    rd_pend_t          pend2_q;
    logic [1:0]        rvalid_d;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    monitor_mem_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (rq_req),
        .ack     (ack)
    );

    assign rq_ack = ack;

    // Route the granted requester's fields toward the memory command register.
    always_comb begin
        xfer      = |ack;
        gnt_id    = ack[1] ? ReqHost : ReqCpu;
        sel_addr  = rq_addr[0 +: ADDR_W];
        sel_be    = rq_be[0 +: BeW];
        sel_write = rq_write[0];
        sel_wdata = rq_wdata[0 +: DATA_W];
        if (ack[1]) begin
            sel_addr  = rq_addr[ADDR_W +: ADDR_W];
            sel_be    = rq_be[BeW +: BeW];
            sel_write = rq_write[1];
            sel_wdata = rq_wdata[DATA_W +: DATA_W];
        end
    end

    // Memory command register: chip select is high for exactly the cycle after a transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= '0;
            be_q    <= '0;
            cs_q    <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            cs_q    <= xfer;
            write_q <= xfer & sel_write;
            if (xfer) begin
                addr_q  <= sel_addr;
                be_q    <= sel_be;
                wdata_q <= sel_wdata;
            end
        end
    end

    // Decode the slot leaving the pipeline into a one-hot response valid.
    always_comb begin
        rvalid_d = 2'b00;
        if (pend2_q.valid) begin
            rvalid_d = (pend2_q.id == ReqHost) ? 2'b10 : 2'b01;
        end
    end

    // Pending-read pipeline aligned with memory latency; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend1_q  <= '0;
            pend2_q  <= '0;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            pend1_q.valid <= xfer & ~sel_write;
            pend1_q.id    <= gnt_id;
            pend2_q       <= pend1_q;
            rvalid_q      <= rvalid_d;
            if (pend2_q.valid) begin
                rdata_q <= mem_readdata;
            end
        end
    end

    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = write_q;
    assign mem_writedata  = wdata_q;
    assign mem_clken      = 1'b1;
    assign mem_reset_req  = ~reset_n;
    assign rq_rvalid      = rvalid_q;
    assign rq_rdata       = rdata_q;

endmodule

// File: tb/tb_monitor_mem_arbiter.sv
// Bench for monitor_mem_arbiter: directed steps plus a random phase, all checked
// against a transaction-level model (memory image, command and response queues).
module tb_monitor_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Requester-side state, driven by the stimulus tasks.
    logic [1:0]    q_v;
    logic [1:0]    q_w;
    logic [AW-1:0] q_a  [2];
    logic [3:0]    q_be [2];
    logic [DW-1:0] q_d  [2];

    logic [1:0]      rq_req;
    logic [2*AW-1:0] rq_addr;
    logic [7:0]      rq_be;
    logic [1:0]      rq_write;
    logic [2*DW-1:0] rq_wdata;
    logic [1:0]      rq_ack;
    logic [1:0]      rq_rvalid;
    logic [DW-1:0]   rq_rdata;
    logic [AW-1:0]   mem_address;
    logic [3:0]      mem_byteenable;
    logic            mem_chipselect;
    logic            mem_write;
    logic [DW-1:0]   mem_writedata;
    logic            mem_clken;
    logic            mem_reset_req;
    logic [DW-1:0]   mem_readdata;

    assign rq_req   = q_v;
    assign rq_addr  = {q_a[1], q_a[0]};
    assign rq_be    = {q_be[1], q_be[0]};
    assign rq_write = q_w;
    assign rq_wdata = {q_d[1], q_d[0]};

    monitor_mem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rq_req         (rq_req),
        .rq_addr        (rq_addr),
        .rq_be          (rq_be),
        .rq_write       (rq_write),
        .rq_wdata       (rq_wdata),
        .rq_ack         (rq_ack),
        .rq_rvalid      (rq_rvalid),
        .rq_rdata       (rq_rdata),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_reset_req  (mem_reset_req),
        .mem_readdata   (mem_readdata)
    );

    // Synchronous single-port memory attached to the DUT.
    logic [DW-1:0] ram [0:8191] = '{default: '0};
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference model: memory image updated in acceptance order, plus due-cycle queues.
    typedef struct {
        int            due;
        logic          w;
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [DW-1:0] d;
    } cmd_t;
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] d;
    } rsp_t;

    logic [DW-1:0] model_mem [0:8191] = '{default: '0};
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   m_last;
    int   cyc;
    int   total;
    int   bad;
    int   ack_cyc [2];
    int   rv_cyc  [2];
    logic [DW-1:0] rv_data [2];
    logic [1:0]    seen_ack;
    logic          seen_cs;
    logic [1:0]    acks [8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Who the spec says should be granted given the current requests.
    function automatic logic [1:0] model_grant();
        if (!reset_n) return 2'b00;
        if (q_v == 2'b11) begin
`ifdef MONITOR_ARB_HOST_PRIO_EN
            return 2'b10;
`else
            return (m_last == 1) ? 2'b01 : 2'b10;
`endif
        end
        return q_v;
    endfunction

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] d);
        q_v[i]  = 1'b1;
        q_w[i]  = w;
        q_a[i]  = a;
        q_be[i] = be;
        q_d[i]  = d;
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        logic [1:0]    ea;
        logic [1:0]    done;
        logic [DW-1:0] nd;
        cmd_t          c;
        rsp_t          r;
        int            id;
        @(negedge clk);
        ea = model_grant();
        seen_ack = rq_ack;
        seen_cs  = mem_chipselect;
        chk("ack", rq_ack, ea);
        chk("reset_req", mem_reset_req, !reset_n);
        if (reset_n) chk("clken", mem_clken, 1);
        if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
            c = cmd_q.pop_front();
            chk("cs", mem_chipselect, 1);
            chk("mwrite", mem_write, c.w);
            chk("maddr", mem_address, c.a);
            chk("mbe", mem_byteenable, c.be);
            if (c.w) chk("mwdata", mem_writedata, c.d);
        end else begin
            chk("cs_idle", mem_chipselect, 0);
            chk("mwrite_idle", mem_write, 0);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            chk("rvalid", rq_rvalid, 2'b01 << r.id);
            chk("rdata", rq_rdata, r.d);
        end else begin
            chk("rvalid_idle", rq_rvalid, 0);
        end
        for (int i = 0; i < 2; i++) begin
            if (rq_rvalid[i]) begin
                rv_cyc[i]  = cyc;
                rv_data[i] = rq_rdata;
            end
        end
        done = 2'b00;
        if (!reset_n) begin
            cmd_q.delete();
            rsp_q.delete();
            m_last = 1;
        end else if (ea != 2'b00) begin
            id = ea[1] ? 1 : 0;
            cmd_q.push_back('{cyc + 1, q_w[id], q_a[id], q_be[id], q_d[id]});
            if (q_w[id]) begin
                nd = model_mem[q_a[id]];
                for (int b = 0; b < 4; b++) begin
                    if (q_be[id][b]) nd[8*b +: 8] = q_d[id][8*b +: 8];
                end
                model_mem[q_a[id]] = nd;
            end else begin
                rsp_q.push_back('{cyc + 3, id, model_mem[q_a[id]]});
            end
            m_last      = id;
            done[id]    = 1'b1;
            ack_cyc[id] = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (done[i]) q_v[i] = 1'b0;
        end
    endtask

    task automatic wait_rv(input int i, input int since);
        for (int k = 0; k < 10 && rv_cyc[i] <= since; k++) cycle();
        chk("rv_seen", rv_cyc[i] > since, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (q_v != 2'b00 || rsp_q.size() > 0 || cmd_q.size() > 0); k++) cycle();
        chk("drained", {q_v, 1'b0} | (rsp_q.size() > 0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd;
        int base;
        total  = 0;
        bad    = 0;
        cyc    = 0;
        m_last = 1;
        rv_cyc[0] = -1;
        rv_cyc[1] = -1;
        for (int i = 0; i < 2; i++) begin
            q_a[i]  = '0;
            q_be[i] = '0;
            q_d[i]  = '0;
        end
        q_w = 2'b00;

        // Reset state, with both requesters asserting to prove acks are blocked.
        reset_n = 1'b0;
        issue(0, 1'b0, 13'h0, 4'hF, 32'h0);
        issue(1, 1'b0, 13'h0, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", rq_ack, 0);
        chk("rst_rvalid", rq_rvalid, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_be", mem_byteenable, 0);
        chk("rst_wdata", mem_writedata, 0);
        chk("rst_rdata", rq_rdata, 0);
        chk("rst_reset_req", mem_reset_req, 1);
        q_v = 2'b00;
        cycle();
        reset_n = 1'b1;

        // CPU write then read of the same word.
        issue(0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF);
        cycle();
        chk("031_wr_ack", seen_ack, 2'b01);
        issue(0, 1'b0, 13'h0010, 4'hF, 32'h0);
        cycle();
        chk("031_rd_ack", seen_ack, 2'b01);
        rd = cyc - 1;
        wait_rv(0, rd);
        chk("031_lat", rv_cyc[0] - rd, 3);
        chk("031_data", rv_data[0], 32'hDEADBEEF);

        // Partial byte-enable write at the top address.
        issue(0, 1'b1, 13'h1FFF, 4'b0101, 32'h11223344);
        cycle();
        issue(0, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        cycle();
        rd = cyc - 1;
        wait_rv(0, rd);
        chk("033_data", rv_data[0], 32'h00220044);

        // Cross-requester write followed immediately by a read of the same word.
        issue(0, 1'b1, 13'h0100, 4'hF, 32'hCAFEF00D);
        cycle();
        issue(1, 1'b0, 13'h0100, 4'hF, 32'h0);
        cycle();
        chk("036_rd_ack", seen_ack, 2'b10);
        rd = cyc - 1;
        wait_rv(1, rd);
        chk("036_data", rv_data[1], 32'hCAFEF00D);
        drain();

        // Both requesters reading every cycle.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!q_v[i]) issue(i, 1'b0, AW'($urandom_range(0, 31)), 4'hF, 32'h0);
            end
            cycle();
            acks[k] = seen_ack;
            if (k > 0) chk("032_cs", seen_cs, 1);
        end
`ifdef MONITOR_ARB_HOST_PRIO_EN
        for (int k = 0; k < 4; k++) chk("035_host", acks[k], 2'b10);
        chk("035_cpu_starved", q_v[0], 1);
`else
        chk("032_first", acks[0] == 2'b01 || acks[0] == 2'b10, 1);
        for (int k = 1; k < 8; k++) chk("032_alt", acks[k], {acks[k-1][0], acks[k-1][1]});
`endif
        drain();

        // Reset right after two read acks drops both responses.
        issue(0, 1'b0, 13'h0010, 4'hF, 32'h0);
        issue(1, 1'b0, 13'h0100, 4'hF, 32'h0);
        cycle();
        cycle();
        reset_n = 1'b0;
        base = cyc;
        cycle();
        reset_n = 1'b1;
        chk("034_cs", mem_chipselect, 0);
        chk("034_rvalid", rq_rvalid, 0);
        chk("034_rdata", rq_rdata, 0);
        chk("034_addr", mem_address, 0);
        repeat (6) cycle();
        chk("034_no_rv", rv_cyc[0] < base && rv_cyc[1] < base, 1);

        // Random mixed traffic with hazards on a small address window and rare resets.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!q_v[i] && $urandom_range(0, 99) < 70) begin
                    issue(i, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 13'h1FFF : AW'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)), $urandom);
                end
            end
            reset_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        reset_n = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
